// File: rtl/jtag_scan_registers.sv
// JTAG instruction register and IDCODE/BYPASS/ABORT/USER data-register chains,
// driven by one-hot TAP state strobes; USER is also exposed as a parallel port.
module jtag_scan_registers #(
   parameter int                   IR_WIDTH     = 4,
   parameter logic [31:0]          IDCODE_VALUE = 32'h000FAF01,
   parameter int                   USER_WIDTH   = 8,
   parameter logic [IR_WIDTH-1:0]  INSTR_IDCODE = 4'b1110,
   parameter logic [IR_WIDTH-1:0]  INSTR_BYPASS = 4'b1111,
   parameter logic [IR_WIDTH-1:0]  INSTR_ABORT  = 4'b1000,
   parameter logic [IR_WIDTH-1:0]  INSTR_USER   = 4'b1010
) (
   input  logic                  tck,
   input  logic                  trst_n,
   input  logic                  tdi,
   input  logic                  test_logic_reset,
   input  logic                  capture_ir,
   input  logic                  shift_ir,
   input  logic                  update_ir,
   input  logic                  capture_dr,
   input  logic                  shift_dr,
   input  logic                  update_dr,
   input  logic [USER_WIDTH-1:0] user_dr_in,
   output logic                  tdo,
   output logic [IR_WIDTH-1:0]   ir,
   output logic [USER_WIDTH-1:0] user_dr_out,
   output logic                  user_dr_update,
   output logic                  abort_pulse
);

   localparam logic [IR_WIDTH-1:0] IR_CAPTURE = {{(IR_WIDTH-1){1'b0}}, 1'b1};

   logic [IR_WIDTH-1:0]   ir_r;
   logic [IR_WIDTH-1:0]   ir_shift_r;
   logic [31:0]           dr_shift_r;
   logic [USER_WIDTH-1:0] user_dr_out_r;
   logic                  user_dr_update_r;
   logic                  abort_pulse_r;
   logic [5:0]            dr_len_s;
   logic [31:0]           dr_down_s;
   logic [31:0]           dr_shifted_s;
   logic [31:0]           dr_capture_s;

   assign dr_down_s = {1'b0, dr_shift_r[31:1]};

   // Length of the DR chain selected by the active instruction
   always_comb begin
      dr_len_s = 6'd1;
      case (ir_r)
         INSTR_IDCODE: dr_len_s = 6'd32;
         INSTR_USER:   dr_len_s = 6'(USER_WIDTH);
         default:      dr_len_s = 6'd1;
      endcase
   end

   // One shift step over the selected length; bits beyond it hold their value
   always_comb begin
      dr_shifted_s = dr_shift_r;
      for (int i = 0; i < 32; i++) begin
         if (i == int'(dr_len_s) - 1) begin
            dr_shifted_s[i] = tdi;
         end else if (i < int'(dr_len_s) - 1) begin
            dr_shifted_s[i] = dr_down_s[i];
         end else begin
            dr_shifted_s[i] = dr_shift_r[i];
         end
      end
   end

   // Value parallel-loaded into the DR chain at Capture-DR
   always_comb begin
      dr_capture_s = dr_shift_r;
      case (ir_r)
         INSTR_IDCODE: dr_capture_s = IDCODE_VALUE;
         INSTR_USER:   dr_capture_s = 32'(user_dr_in);
         default:      dr_capture_s[0] = 1'b0;
      endcase
   end

   // Strobe-priority state update; update pulses clear themselves every cycle
   always_ff @(posedge tck or negedge trst_n) begin
      if (!trst_n) begin
         ir_r             <= INSTR_IDCODE;
         ir_shift_r       <= IR_CAPTURE;
         dr_shift_r       <= 32'd0;
         user_dr_out_r    <= {USER_WIDTH{1'b0}};
         user_dr_update_r <= 1'b0;
         abort_pulse_r    <= 1'b0;
      end else begin
         user_dr_update_r <= 1'b0;
         abort_pulse_r    <= 1'b0;
         if (test_logic_reset) begin
            ir_r <= INSTR_IDCODE;
         end else if (capture_ir) begin
            ir_shift_r <= IR_CAPTURE;
         end else if (shift_ir) begin
            ir_shift_r <= {tdi, ir_shift_r[IR_WIDTH-1:1]};
         end else if (update_ir) begin
            ir_r <= ir_shift_r;
         end else if (capture_dr) begin
            dr_shift_r <= dr_capture_s;
         end else if (shift_dr) begin
            dr_shift_r <= dr_shifted_s;
         end else if (update_dr) begin
            if (ir_r == INSTR_USER) begin
               user_dr_out_r    <= dr_shift_r[USER_WIDTH-1:0];
               user_dr_update_r <= 1'b1;
            end else if (ir_r == INSTR_ABORT) begin
               abort_pulse_r <= 1'b1;
            end
         end
      end
   end

   // TDO must present the bit leaving the chain at the coming edge, so it stays combinational
   assign tdo            = shift_ir ? ir_shift_r[0] : (shift_dr ? dr_shift_r[0] : 1'b0);
   assign ir             = ir_r;
   assign user_dr_out    = user_dr_out_r;
   assign user_dr_update = user_dr_update_r;
   assign abort_pulse    = abort_pulse_r;

endmodule

// File: tb/tb_jtag_scan_registers.sv
// Scoreboard bench for jtag_scan_registers: stimulus pushes model predictions,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_jtag_scan_registers;

   localparam int             IRW     = 4;
   localparam int             UW      = 8;
   localparam logic [31:0]    IDC_VAL = 32'h000FAF01;
   localparam logic [IRW-1:0] OP_IDC  = 4'b1110;
   localparam logic [IRW-1:0] OP_BYP  = 4'b1111;
   localparam logic [IRW-1:0] OP_ABT  = 4'b1000;
   localparam logic [IRW-1:0] OP_USR  = 4'b1010;

   // strobe vector: [6]=tlr [5]=cir [4]=sir [3]=uir [2]=cdr [1]=sdr [0]=udr
   localparam logic [6:0] S_IDLE = 7'b0000000;
   localparam logic [6:0] S_TLR  = 7'b1000000;
   localparam logic [6:0] S_CIR  = 7'b0100000;
   localparam logic [6:0] S_SIR  = 7'b0010000;
   localparam logic [6:0] S_UIR  = 7'b0001000;
   localparam logic [6:0] S_CDR  = 7'b0000100;
   localparam logic [6:0] S_SDR  = 7'b0000010;
   localparam logic [6:0] S_UDR  = 7'b0000001;

   logic           tck = 1'b0;
   logic           trst_n = 1'b0;
   logic           tdi = 1'b0;
   logic [6:0]     strobes = 7'b0000000;
   logic [UW-1:0]  user_dr_in = 8'h00;
   logic           tdo;
   logic [IRW-1:0] ir;
   logic [UW-1:0]  user_dr_out;
   logic           user_dr_update;
   logic           abort_pulse;

   always #5 tck = ~tck;

   jtag_scan_registers dut (
      .tck(tck), .trst_n(trst_n), .tdi(tdi),
      .test_logic_reset(strobes[6]), .capture_ir(strobes[5]), .shift_ir(strobes[4]),
      .update_ir(strobes[3]), .capture_dr(strobes[2]), .shift_dr(strobes[1]),
      .update_dr(strobes[0]), .user_dr_in(user_dr_in), .tdo(tdo), .ir(ir),
      .user_dr_out(user_dr_out), .user_dr_update(user_dr_update), .abort_pulse(abort_pulse)
   );

   typedef struct {
      int          kind;   // 0 ir, 1 user_dr_out, 2 user_dr_update, 3 abort_pulse
      logic [31:0] val;
   } chk_t;

   logic          q_tdo[$];
   logic [UW-1:0] q_upd[$];
   bit            q_abort[$];
   chk_t          q_chk[$];

   int  tests = 0;
   int  fails = 0;
   bit  done = 1'b0;

   // reference model state
   logic [IRW-1:0] m_ir;
   logic [IRW-1:0] m_irs;
   logic [31:0]    m_dr;

   function automatic int dr_len(input logic [IRW-1:0] op);
      if (op == OP_IDC) return 32;
      else if (op == OP_USR) return UW;
      else return 1;
   endfunction

   task automatic push_chk(input int kind, input logic [31:0] val);
      chk_t c;
      c.kind = kind;
      c.val  = val;
      q_chk.push_back(c);
   endtask

   // one TCK cycle: predict, drive, advance the model, wait past the edge
   task automatic step(input logic [6:0] s, input logic t);
      int          len;
      logic [63:0] mask;
      strobes = s;
      tdi     = t;
      q_tdo.push_back(s[4] ? m_irs[0] : (s[1] ? m_dr[0] : 1'b0));
      len  = dr_len(m_ir);
      mask = (64'd1 << len) - 64'd1;
      if (s[6]) m_ir = OP_IDC;
      else if (s[5]) m_irs = 4'd1;
      else if (s[4]) m_irs = (m_irs >> 1) | (IRW'(t) << (IRW - 1));
      else if (s[3]) m_ir = m_irs;
      else if (s[2]) begin
         if (m_ir == OP_IDC) m_dr = IDC_VAL;
         else if (m_ir == OP_USR) m_dr = 32'(user_dr_in);
         else m_dr = m_dr & ~32'd1;
      end else if (s[1]) begin
         m_dr = (m_dr & ~mask[31:0]) | ((m_dr & mask[31:0]) >> 1) | (32'(t) << (len - 1));
      end else if (s[0]) begin
         if (m_ir == OP_USR) q_upd.push_back(m_dr[UW-1:0]);
         else if (m_ir == OP_ABT) q_abort.push_back(1'b1);
      end
      @(posedge tck);
      #1;
   endtask

   task automatic do_reset();
      strobes = S_IDLE;
      trst_n  = 1'b0;
      m_ir  = OP_IDC;
      m_irs = 4'd1;
      m_dr  = 32'd0;
      q_tdo.push_back(1'b0);
      push_chk(0, 32'(OP_IDC));
      push_chk(1, 32'd0);
      push_chk(2, 32'd0);
      push_chk(3, 32'd0);
      #6;
      trst_n = 1'b1;
      @(posedge tck);
      #1;
   endtask

   task automatic ir_scan(input logic [IRW-1:0] op);
      step(S_CIR, 1'b0);
      for (int i = 0; i < IRW; i++) step(S_SIR, op[i]);
      step(S_UIR, 1'b0);
   endtask

   task automatic dr_scan(input int n, input logic [63:0] data, input bit upd);
      step(S_CDR, 1'b0);
      for (int i = 0; i < n; i++) step(S_SDR, data[i]);
      if (upd) step(S_UDR, 1'b0);
      step(S_IDLE, 1'b0);
   endtask

   function automatic logic [IRW-1:0] pick_op();
      case ($urandom_range(0, 4))
         0: return OP_IDC;
         1: return OP_BYP;
         2: return OP_ABT;
         3: return OP_USR;
         default: return IRW'($urandom);
      endcase
   endfunction

   // monitor / scoreboard
   always @(negedge tck) begin
      if (q_tdo.size() > 0) begin
         logic e;
         e = q_tdo.pop_front();
         tests++;
         if (tdo !== e) begin
            fails++;
            $display("FAIL tdo: got %b expected %b at %0t", tdo, e, $time);
         end
      end
      if (user_dr_update === 1'b1) begin
         tests++;
         if (q_upd.size() == 0) begin
            fails++;
            $display("FAIL user_dr_update: got unexpected pulse expected none at %0t", $time);
         end else begin
            logic [UW-1:0] ev;
            ev = q_upd.pop_front();
            if (user_dr_out !== ev) begin
               fails++;
               $display("FAIL user_dr_out: got %h expected %h at %0t", user_dr_out, ev, $time);
            end
         end
      end
      if (abort_pulse === 1'b1) begin
         tests++;
         if (q_abort.size() == 0) begin
            fails++;
            $display("FAIL abort_pulse: got unexpected pulse expected none at %0t", $time);
         end else begin
            void'(q_abort.pop_front());
         end
      end
      while (q_chk.size() > 0) begin
         chk_t        c;
         logic [31:0] act;
         c = q_chk.pop_front();
         case (c.kind)
            0:       act = 32'(ir);
            1:       act = 32'(user_dr_out);
            2:       act = 32'(user_dr_update);
            default: act = 32'(abort_pulse);
         endcase
         tests++;
         if (act !== c.val) begin
            fails++;
            $display("FAIL check%0d: got %h expected %h at %0t", c.kind, act, c.val, $time);
         end
      end
      if (done) begin
         tests++;
         if (q_upd.size() != 0 || q_abort.size() != 0) begin
            fails++;
            $display("FAIL missing_pulses: got %0d/%0d outstanding expected 0/0", q_upd.size(), q_abort.size());
         end
         $display("[TB] %0d tests run, %0d failed", tests, fails);
         $finish;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      @(posedge tck);
      #1;
      do_reset();
      // IDCODE read, 33 shifts of zeros
      dr_scan(33, 64'd0, 1'b0);
      // IR scan of all ones -> BYPASS
      ir_scan(4'b1111);
      step(S_IDLE, 1'b0);
      push_chk(0, 32'h0000000F);
      // bypass one-cycle delay
      dr_scan(8, 64'hA5, 1'b0);
      // USER write/read
      ir_scan(OP_USR);
      user_dr_in = 8'h3C;
      dr_scan(8, 64'hA5, 1'b1);
      push_chk(1, 32'h000000A5);
      step(S_IDLE, 1'b0);
      // ABORT pulse
      ir_scan(OP_ABT);
      step(S_UDR, 1'b0);
      step(S_IDLE, 1'b0);
      step(S_IDLE, 1'b0);
      // reset in the middle of a USER scan
      ir_scan(OP_USR);
      step(S_CDR, 1'b0);
      for (int i = 0; i < 3; i++) step(S_SDR, 1'b1);
      do_reset();
      push_chk(0, 32'h0000000E);
      push_chk(1, 32'h00000000);
      step(S_IDLE, 1'b0);
      step(S_UDR, 1'b0);
      step(S_IDLE, 1'b0);
      // randomized traffic
      for (int n = 0; n < 250; n++) begin
         case ($urandom_range(0, 5))
            0: ir_scan(pick_op());
            1: dr_scan($urandom_range(0, 40), {$urandom, $urandom}, 1'($urandom_range(0, 1)));
            2: step(S_UDR, 1'b0);
            3: begin
               user_dr_in = UW'($urandom);
               step(S_IDLE, 1'b0);
            end
            4: step(7'($urandom), 1'($urandom));
            default: begin
               if ($urandom_range(0, 3) == 0) step(S_TLR, 1'b0);
               else step(S_IDLE, 1'($urandom));
            end
         endcase
         step(S_IDLE, 1'b0);
         push_chk(0, 32'(m_ir));
      end
      step(S_IDLE, 1'b0);
      step(S_IDLE, 1'b0);
      done = 1'b1;
   end

endmodule

// File: doc/jtag_scan_registers.md
Name: jtag_scan_registers

Overview:
Instruction register and data-register chains that sit directly downstream of the TAP controller. The block consumes one-hot TAP state strobes and TDI, and drives TDO. It implements IR capture/shift/update plus the IDCODE, BYPASS, ABORT and USER data registers. The USER register is exposed to the core logic as a parallel read/write port.

Parameters:
IR_WIDTH, 4, instruction register width (>=2)
IDCODE_VALUE, 32'h000FAF01, value captured into the DR chain under IDCODE
USER_WIDTH, 8, USER data register width (1..32)
INSTR_IDCODE, 4'b1110, IDCODE opcode
INSTR_BYPASS, 4'b1111, BYPASS opcode
INSTR_ABORT, 4'b1000, ABORT opcode
INSTR_USER, 4'b1010, USER opcode

Ports:
tck  input  1  scan clock; all state updates on posedge tck
trst_n  input  1  asynchronous active-low reset
tdi  input  1  serial data in
test_logic_reset  input  1  TAP is in Test-Logic-Reset
capture_ir  input  1  TAP is in Capture-IR
shift_ir  input  1  TAP is in Shift-IR
update_ir  input  1  TAP is in Update-IR
capture_dr  input  1  TAP is in Capture-DR
shift_dr  input  1  TAP is in Shift-DR
update_dr  input  1  TAP is in Update-DR
user_dr_in  input  USER_WIDTH  parallel value captured under USER
tdo  output  1  serial data out
ir  output  IR_WIDTH  active instruction
user_dr_out  output  USER_WIDTH  last USER value written via Update-DR
user_dr_update  output  1  one-cycle pulse when user_dr_out is loaded
abort_pulse  output  1  one-cycle pulse on Update-DR under ABORT

Behaviour:
- Reset (trst_n=0, asynchronous):
  - ir=INSTR_IDCODE, ir_shift={IR_WIDTH-2 zeros,2'b01}
  - dr_shift=0, user_dr_out=0, user_dr_update=0, abort_pulse=0
  - tdo=0
- test_logic_reset=1 at posedge: ir<=INSTR_IDCODE. Synchronous; no other state changes.
- Strobe priority: at most one strobe is expected per cycle. If several are high, only the highest-priority one acts, in this order: test_logic_reset, capture_ir, shift_ir, update_ir, capture_dr, shift_dr, update_dr.
- capture_ir: ir_shift <= {zeros,2'b01}.
- shift_ir: ir_shift <= {tdi, ir_shift[IR_WIDTH-1:1]}.
- update_ir: ir <= ir_shift. A new instruction takes effect only at Update-IR.
- Selected DR length L depends on ir:
  - IDCODE: L=32
  - USER: L=USER_WIDTH
  - BYPASS, ABORT or any unlisted opcode: L=1 (bypass)
- capture_dr loads dr_shift (32-bit internal register):
  - IDCODE: dr_shift <= IDCODE_VALUE
  - USER: dr_shift[USER_WIDTH-1:0] <= user_dr_in, upper bits <= 0
  - bypass: dr_shift[0] <= 0
- shift_dr: dr_shift[L-1:0] <= {tdi, dr_shift[L-1:1]}. Bits at index L and above hold their value.
- update_dr:
  - USER: user_dr_out <= dr_shift[USER_WIDTH-1:0]; user_dr_update=1 for exactly the next cycle.
  - ABORT: abort_pulse=1 for exactly the next cycle.
  - Other instructions: no effect.
- Pulses are registered and self-clear after one cycle. Update-DR held N cycles produces N pulses; the TAP never holds Update-DR longer than one cycle.
- tdo (combinational):
  - shift_ir=1: ir_shift[0]
  - else shift_dr=1: dr_shift[0]
  - else: 0
  - The bit presented at a posedge is the one shifted out at that edge. Data leaves LSB-first.
- Wrap-around: shifting more than L bits makes TDI data re-emerge on TDO after L cycles. Shifting fewer than L bits leaves the unshifted captured bits in place, and Update uses the partial contents.
- Reset mid-scan: trst_n low during any shift aborts it immediately. All registers take reset values and no update pulse is generated.
- ir is never X after reset.

Test Plan:
- Reset: trst_n pulsed low, all strobes 0 -> ir=4'b1110, tdo=0, user_dr_update=0, abort_pulse=0.
- IDCODE read: capture_dr 1 cycle, then shift_dr 32 cycles with tdi=0 -> TDO bits LSB-first equal 32'h000FAF01; 33rd shift bit is 0.
- IR scan: capture_ir, then shift_ir 4 cycles with tdi=1,1,1,1 -> TDO shows 1,0,0,0 (capture pattern). After update_ir, ir=4'b1111.
- Bypass: with ir=BYPASS, capture_dr then shift 8 cycles with tdi=1,0,1,0,0,1,0,1 -> TDO = 0,1,0,1,0,0,1,0 (one-cycle delay).
- USER write/read: load ir=4'b1010, user_dr_in=8'h3C. Capture_dr, then shift 8 cycles with tdi LSB-first of 8'hA5 -> TDO gives 8'h3C LSB-first. Update_dr -> user_dr_out=8'hA5, user_dr_update high exactly 1 cycle.
- ABORT and reset mid-op: ir=4'b1000, update_dr -> abort_pulse high 1 cycle. Separately, trst_n asserted after 3 of 8 USER shift cycles -> ir=4'b1110, user_dr_out=0, no user_dr_update.
